// File: rtl/sprite_palette_engine.sv
// Banked, runtime-writable RGB palette with a fixed two-stage lookup,
// transparency flagging and a frame-tick-driven hit-flash override.
module sprite_palette_engine #(
   parameter  int IDX_W           = 4,
   parameter  int CH_W            = 4,
   parameter  int NUM_BANKS       = 4,
   parameter  int TRANSPARENT_IDX = 0,
   parameter  int FLASH_W         = 4,
   localparam int BANK_W          = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic                pix_valid,
   input  logic [IDX_W-1:0]    pix_index,
   input  logic [BANK_W-1:0]   pix_bank,
   input  logic                wr_en,
   input  logic [BANK_W-1:0]   wr_bank,
   input  logic [IDX_W-1:0]    wr_idx,
   input  logic [3*CH_W-1:0]   wr_rgb,
   input  logic                frame_tick,
   input  logic                flash_start,
   input  logic [FLASH_W-1:0]  flash_toggles,
   output logic                out_valid,
   output logic [CH_W-1:0]     red,
   output logic [CH_W-1:0]     green,
   output logic [CH_W-1:0]     blue,
   output logic                out_transparent,
   output logic                flash_active
);

   localparam int                 RGB_W  = 3 * CH_W;
   localparam int                 ADDR_W = BANK_W + IDX_W;
   localparam logic [BANK_W:0]    NB     = (BANK_W + 1)'(NUM_BANKS);
   localparam logic [IDX_W-1:0]   TIDX   = IDX_W'(TRANSPARENT_IDX);

   typedef enum logic [1:0] {FL_IDLE, FL_ON, FL_OFF} flash_e;

   // Palette storage: deliberately not reset
   logic [RGB_W-1:0] mem [2**ADDR_W];

   logic [ADDR_W-1:0] wr_addr, pix_addr;
   logic              wr_ok, pix_ok;

   assign wr_addr  = {wr_bank, wr_idx};
   assign pix_addr = {pix_bank, pix_index};
   assign wr_ok    = wr_en && ({1'b0, wr_bank} < NB);
   assign pix_ok   = {1'b0, pix_bank} < NB;

   always_ff @(posedge Clk) begin
      if (wr_ok) mem[wr_addr] <= wr_rgb;
   end

   // ---------------- S1: RAM read with write-first bypass ----------------
   logic [1:0]       vld_pipe_q;
   logic [RGB_W-1:0] s1_rgb_q, s1_rgb_d;
   logic             s1_tr_q;

   always_comb begin
      s1_rgb_d = '0;
      if (pix_ok) s1_rgb_d = (wr_ok && wr_addr == pix_addr) ? wr_rgb : mem[pix_addr];
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         vld_pipe_q <= '0;
         s1_rgb_q   <= '0;
         s1_tr_q    <= 1'b0;
      end else begin
         vld_pipe_q <= {vld_pipe_q[0], pix_valid};
         if (pix_valid) begin
            s1_rgb_q <= s1_rgb_d;
            s1_tr_q  <= (pix_index == TIDX);
         end
      end
   end

   // ---------------- Flash FSM ----------------
   flash_e             state_q;
   logic [FLASH_W-1:0] cnt_q;
   logic               active_q;

   // A restart wins over a same-cycle frame tick
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= FL_IDLE;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else if (flash_start && flash_toggles != '0) begin
         state_q  <= FL_ON;
         cnt_q    <= flash_toggles;
         active_q <= 1'b1;
      end else if (state_q != FL_IDLE && frame_tick) begin
         cnt_q <= cnt_q - 1'b1;
         if (cnt_q == FLASH_W'(1)) begin
            state_q  <= FL_IDLE;
            active_q <= 1'b0;
         end else begin
            state_q  <= (state_q == FL_ON) ? FL_OFF : FL_ON;
         end
      end
   end

   // ---------------- S2: flash override and output registers ----------------
   logic [RGB_W-1:0] out_rgb_q, out_rgb_d;
   logic             out_tr_q;

   assign out_rgb_d = (state_q == FL_ON && !s1_tr_q) ? {RGB_W{1'b1}} : s1_rgb_q;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         out_rgb_q <= '0;
         out_tr_q  <= 1'b0;
      end else if (vld_pipe_q[0]) begin
         out_rgb_q <= out_rgb_d;
         out_tr_q  <= s1_tr_q;
      end
   end

   assign out_valid       = vld_pipe_q[1];
   assign red             = out_rgb_q[3*CH_W-1:2*CH_W];
   assign green           = out_rgb_q[2*CH_W-1:CH_W];
   assign blue            = out_rgb_q[CH_W-1:0];
   assign out_transparent = out_tr_q;
   assign flash_active    = active_q;

endmodule

// File: tb/tb_sprite_palette_engine.sv
// Scoreboard bench: a behavioural palette/flash model queues expected pixels,
// a monitor pops and compares them whenever out_valid is seen.
module tb_sprite_palette_engine;

   localparam int IDX_W = 4, CH_W = 4, NB = 3, BW = 2, FW = 4;

   logic          Clk = 0, Reset_n = 0;
   logic          pix_valid = 0, wr_en = 0, frame_tick = 0, flash_start = 0;
   logic [IDX_W-1:0] pix_index = 0, wr_idx = 0;
   logic [BW-1:0] pix_bank = 0, wr_bank = 0;
   logic [11:0]   wr_rgb = 0;
   logic [FW-1:0] flash_toggles = 0;
   logic          out_valid, out_transparent, flash_active;
   logic [CH_W-1:0] red, green, blue;

   sprite_palette_engine #(.IDX_W(IDX_W), .CH_W(CH_W), .NUM_BANKS(NB),
                           .TRANSPARENT_IDX(0), .FLASH_W(FW)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .pix_index(pix_index),
      .pix_bank(pix_bank), .wr_en(wr_en), .wr_bank(wr_bank), .wr_idx(wr_idx),
      .wr_rgb(wr_rgb), .frame_tick(frame_tick), .flash_start(flash_start),
      .flash_toggles(flash_toggles), .out_valid(out_valid), .red(red), .green(green),
      .blue(blue), .out_transparent(out_transparent), .flash_active(flash_active));

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int total = 0, bad = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   typedef struct { logic [11:0] rgb; bit tr; int due; } exp_t;
   exp_t q[$];

   // Reference model: palette contents and flash as "toggles loaded / remaining"
   logic [11:0] pal [4][16];
   int f_load = 0, f_rem = 0;
   bit p_v = 0, p_tr = 0;
   logic [11:0] p_rgb = 0;
   int p_due = 0;

   function automatic bit f_on();
      return (f_rem != 0) && (((f_load - f_rem) % 2) == 0);
   endfunction

   task automatic step(input bit v, input int b, input int i,
                       input bit we, input int wb, input int wi, input logic [11:0] wd,
                       input bit tick, input bit fs, input int ft);
      exp_t e;
      pix_valid = v; pix_bank = BW'(b); pix_index = IDX_W'(i);
      wr_en = we; wr_bank = BW'(wb); wr_idx = IDX_W'(wi); wr_rgb = wd;
      frame_tick = tick; flash_start = fs; flash_toggles = FW'(ft);
      // A lookup issued last cycle sees the flash phase that holds now
      if (p_v) begin
         e.rgb = (f_on() && !p_tr) ? 12'hFFF : p_rgb;
         e.tr  = p_tr;
         e.due = p_due;
         q.push_back(e);
      end
      p_v = v;
      if (v) begin
         p_tr  = (i == 0);
         p_due = cyc + 2;
         if (b >= NB)                          p_rgb = 12'h000;
         else if (we && wb == b && wi == i)    p_rgb = wd;
         else                                  p_rgb = pal[b][i];
      end
      if (we && wb < NB) pal[wb][wi] = wd;
      if (fs && ft != 0) begin
         f_load = ft; f_rem = ft;
      end else if (f_rem != 0 && tick) begin
         f_rem--;
      end
      @(posedge Clk); #1;
      chk("flash_active", {31'd0, flash_active}, {31'd0, (f_rem != 0)});
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic look(input int b, input int i);
      step(1, b, i, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wr(input int b, input int i, input logic [11:0] d);
      step(0, 0, 0, 1, b, i, d, 0, 0, 0);
   endtask

   // Monitor: every out_valid must match the head of the scoreboard, on time
   always @(negedge Clk) begin
      if (Reset_n && out_valid) begin
         if (q.size() == 0) begin
            chk("spurious_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("pixel", {19'd0, out_transparent, red, green, blue}, {19'd0, e.tr, e.rgb});
            chk("latency", cyc, e.due);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge Clk);
      #1 chk("reset_out", {26'd0, out_valid, out_transparent, red, green, blue, flash_active}, 32'd0);
      #2 Reset_n = 1;
      @(posedge Clk); #1;

      // Define every palette entry so the model never holds unknowns
      for (int b = 0; b < NB; b++)
         for (int i = 0; i < 16; i++) wr(b, i, 12'($urandom));

      // Write then read back
      wr(1, 5, 12'hF91);
      look(1, 5);
      idle(2);

      // Transparency, also under flash ON
      wr(0, 0, 12'hABC);
      look(0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
      look(0, 0);
      look(1, 5);
      idle(2);

      // Same-cycle write/lookup collision
      wr(2, 3, 12'h777);
      step(1, 2, 3, 1, 2, 3, 12'h123, 0, 0, 0);
      look(2, 3);
      idle(2);

      // Flash sequence with lookups in each phase (restart to 3)
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
      for (int k = 0; k < 4; k++) begin
         look(1, 5);
         look(0, 0);
         step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      end
      look(1, 5);
      idle(2);

      // Restart mid-OFF with a simultaneous tick
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      look(1, 5);
      step(1, 1, 5, 0, 0, 0, 0, 1, 1, 5);
      look(1, 5);
      idle(1);

      // Reset mid-lookup: everything drops immediately, nothing stale afterwards
      look(1, 5);
      look(2, 3);
      #1 Reset_n = 0;
      #1 chk("reset_mid", {26'd0, out_valid, out_transparent, red, green, blue, flash_active}, 32'd0);
      q.delete(); p_v = 0; f_rem = 0; f_load = 0;
      pix_valid = 0; wr_en = 0; flash_start = 0; frame_tick = 0;
      repeat (2) @(posedge Clk);
      #3 Reset_n = 1;
      @(posedge Clk); #1;
      idle(3);

      // Back-to-back stream, then out-of-range bank access
      look(0, 1); look(0, 2); look(0, 3);
      idle(2);
      step(0, 0, 0, 1, 3, 7, 12'h5A5, 0, 0, 0);
      look(3, 7);
      look(3, 0);
      idle(2);

      // Randomized traffic
      for (int k = 0; k < 600; k++) begin
         int b, i, wb, wi;
         b  = $urandom_range(0, 3);
         i  = $urandom_range(0, 15);
         wb = ($urandom % 4 == 0) ? b : $urandom_range(0, 3);
         wi = ($urandom % 4 == 0) ? i : $urandom_range(0, 15);
         step($urandom % 4 != 0, b, i, $urandom % 3 == 0, wb, wi, 12'($urandom),
              $urandom % 6 == 0, $urandom % 25 == 0, $urandom_range(0, 5));
      end
      idle(4);
      chk("queue_drained", q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sprite_palette_engine.md
Name: sprite_palette_engine

Overview:
- Parametrised, runtime-writable palette lookup for sprite renderers; successor to the fixed 16-entry ROM palettes used per sprite.
- Holds NUM_BANKS banks of 2^IDX_W RGB entries, so tanks and teams can share one instance with per-sprite bank select.
- Adds a 2-stage registered lookup, transparency flagging and a frame-tick-driven hit-flash mode.
- Sits between the sprite ROM index output and the VGA colour mux.

Parameters:
- IDX_W, 4, colour index width; 2^IDX_W entries per bank.
- CH_W, 4, bits per colour channel.
- NUM_BANKS, 4, number of palette banks; BANK_W = max(1, clog2(NUM_BANKS)).
- TRANSPARENT_IDX, 0, index that is reported transparent in every bank.
- FLASH_W, 4, width of the flash-toggle counter.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- pix_valid  in  1  lookup request this cycle.
- pix_index  in  IDX_W  colour index to look up.
- pix_bank  in  BANK_W  bank to look up.
- wr_en  in  1  palette write strobe.
- wr_bank  in  BANK_W  write bank.
- wr_idx  in  IDX_W  write index.
- wr_rgb  in  3*CH_W  write data {r,g,b}.
- frame_tick  in  1  one-cycle pulse per video frame.
- flash_start  in  1  start or restart hit flash.
- flash_toggles  in  FLASH_W  number of on/off phases to run.
- out_valid  out  1  red/green/blue/out_transparent valid.
- red  out  CH_W  red channel.
- green  out  CH_W  green channel.
- blue  out  CH_W  blue channel.
- out_transparent  out  1  pixel index was TRANSPARENT_IDX.
- flash_active  out  1  flash sequence in progress.

Behaviour:
Interface:
- One clock (Clk).
- Reset is asynchronous and active-low (Reset_n).

Reset:
- out_valid, red, green, blue, out_transparent and flash_active are 0.
- Flash FSM in IDLE; pipeline valid bits cleared.
- Palette RAM is not reset; its contents are undefined until written.
- Reset asserted mid-operation drops all in-flight lookups and aborts any flash.

Lookup pipeline (fixed latency 2, no stalls, one lookup per cycle):
- S1 registers the RAM read of {pix_bank, pix_index}, plus pix_valid and the transparency flag (pix_index == TRANSPARENT_IDX).
- S2 applies the flash override, then registers outputs; out_valid = S1 valid.
- When out_valid = 0, outputs hold their last values.

Writes:
- Take effect at the rising edge where wr_en = 1.
- Write-first bypass: if wr_en is high with the same {bank, idx} as a lookup in the same cycle, the lookup returns wr_rgb.
- pix_bank or wr_bank >= NUM_BANKS: writes are ignored; lookups return 0 with out_transparent still computed from the index.

Flash FSM (states IDLE, ON, OFF):
- IDLE -> ON on flash_start with flash_toggles != 0; remaining count loads flash_toggles.
- flash_start with flash_toggles == 0 is ignored.
- In ON or OFF, each frame_tick decrements the remaining count and switches phase.
- Reaching count 0 on a frame_tick returns the FSM to IDLE.
- flash_start while in ON or OFF restarts: go to ON and reload the count. This has priority over a frame_tick in the same cycle.
- flash_active = 1 in ON and OFF, registered.
- Override applies in S2 while the FSM is ON: non-transparent pixels output all-ones on every channel. Transparent pixels are never overridden.

Width rules:
- wr_rgb splits MSB-first: red = [3*CH_W-1 : 2*CH_W], green next, blue in the LSBs.
- No arithmetic on colours.

Test Plan:
1. Write and read back:
   - Stimulus: write bank 1 idx 5 = 12'hF91, then lookup bank 1 idx 5.
   - Response: exactly 2 cycles later, out_valid = 1 and red/green/blue = F/9/1, out_transparent = 0.
2. Transparency:
   - Stimulus: write bank 0 idx 0 = 12'hABC, then lookup idx 0.
   - Response: out_transparent = 1, colour = A/B/C. Also assert flash ON and repeat the lookup: colour stays A/B/C.
3. Same-cycle collision:
   - Stimulus: write bank 2 idx 3 = 12'h123 while looking up bank 2 idx 3; the old value is 12'h777.
   - Response: output is 1/2/3.
4. Flash sequence:
   - Stimulus: flash_start with flash_toggles = 3, then frame_ticks.
   - Response: ON for the first frame, OFF for the second, ON for the third, then IDLE and flash_active = 0. A non-transparent lookup reads F/F/F only in ON phases.
5. Restart and reset:
   - Stimulus: flash_start mid-OFF with a simultaneous frame_tick.
   - Response: FSM is ON with the count reloaded.
   - Stimulus: assert Reset_n = 0 mid-lookup.
   - Response: out_valid, all colours and flash_active go to 0 immediately; no stale out_valid after release.
6. Pipelined stream:
   - Stimulus: back-to-back lookups of idx 1,2,3 in bank 0.
   - Response: three consecutive out_valid cycles with the matching colours, in order.
